vga_timing_gen: RTL and testbench

//  Generates 640x480@60 VGA raster timing from the system clock and drives the Renderer's

---
 rtl/vga_timing_gen_pkg.sv | 35 +++
 rtl/vga_timing_gen_sync_delay.sv | 41 ++++
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Holds the output widths that the Renderer also uses (pixel column/row and
// animation frame index), the default 640x480@60 geometry, and a small
// helper for sizing counters.
package vga_timing_gen_pkg;

    // Widths shared with the Renderer's pixel-request interface.
    localparam int WIDTH_LOG2               = 10;
    localparam int HEIGHT_LOG2              = 9;
    localparam int MAX_ANIMATION_FRAME_LOG2 = 3;

    // Default 640x480@60 geometry, in pixels and lines.
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Undelayed sync levels, both active-low.
    typedef struct packed {
        logic hs;
        logic vs;
    } sync_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay_line: DEPTH-stage shift register for the sync pair, advancing
// only when en is high. Every stage resets to all-ones so the active-low
// syncs stay deasserted until real raster values have shifted through.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   en        shift enable (one pixel tick)
//   din       value entering stage 0
//   dout      value leaving the last stage
module sync_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '1;
        end else if (en) begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the Renderer and the VGA connector.
// A clock divider produces a registered one-clk pixel strobe; on each strobe
// the horizontal/vertical counters advance and the pixel-request outputs are
// registered from the pre-advance counter values. hsync/vsync are delayed by
// SYNC_DELAY extra pixel ticks so they line up with the Renderer's rgb.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   pix_en       one-clk pixel strobe
//   x, y         active-region pixel column/row, 0 in blanking
//   toDisplay    high while (x,y) is in the active region
//   hsync, vsync active-low syncs, delayed
//   frame_start  one-clk pulse as the raster wraps to (0,0)
//   anim_frame   animation frame index, advances every ANIM_DIV frames
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int PIX_DIV    = 4,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int SYNC_DELAY = 1,
    parameter int ANIM_DIV   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                pix_en,
    output logic [WIDTH_LOG2-1:0]               x,
    output logic [HEIGHT_LOG2-1:0]              y,
    output logic                                toDisplay,
    output logic                                hsync,
    output logic                                vsync,
    output logic                                frame_start,
    output logic [MAX_ANIMATION_FRAME_LOG2-1:0] anim_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = cnt_width(PIX_DIV);
    // One spare count so the sync-end bound is representable even with no back porch.
    localparam int HW = cnt_width(H_TOTAL + 1);
    localparam int VW = cnt_width(V_TOTAL + 1);
    localparam int FW = cnt_width(ANIM_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [FW-1:0] F_LAST   = FW'(ANIM_DIV - 1);

    logic [DW-1:0]                       div_cnt_q, div_cnt_d;
    logic                                pix_en_q, pix_en_d;
    logic [HW-1:0]                       h_cnt_q, h_cnt_d;
    logic [VW-1:0]                       v_cnt_q, v_cnt_d;
    logic [WIDTH_LOG2-1:0]               x_q, x_d;
    logic [HEIGHT_LOG2-1:0]              y_q, y_d;
    logic                                to_display_q, to_display_d;
    logic                                frame_start_q, frame_start_d;
    logic [FW-1:0]                       frame_cnt_q, frame_cnt_d;
    logic [MAX_ANIMATION_FRAME_LOG2-1:0] anim_frame_q, anim_frame_d;

    logic  div_last, h_last, v_last, h_act, v_act, frame_wrap;
    sync_t raw_sync;
    logic [1:0] sync_dly;

    always_comb begin
        div_last   = (div_cnt_q == DIV_LAST);
        h_last     = (h_cnt_q == H_LAST);
        v_last     = (v_cnt_q == V_LAST);
        h_act      = (h_cnt_q < H_ACT);
        v_act      = (v_cnt_q < V_ACT);
        frame_wrap = pix_en_q && h_last && v_last;

        div_cnt_d     = div_last ? '0 : div_cnt_q + 1'b1;
        // Registered strobe: high in the clk after the divider's last count.
        pix_en_d      = div_last;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        to_display_d  = to_display_q;
        frame_start_d = frame_wrap;
        frame_cnt_d   = frame_cnt_q;
        anim_frame_d  = anim_frame_q;

        raw_sync.hs = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        raw_sync.vs = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

        if (pix_en_q) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end
            // Outputs describe the pixel the counters pointed at before advancing.
            to_display_d = h_act && v_act;
            x_d          = h_act ? WIDTH_LOG2'(h_cnt_q) : '0;
            y_d          = v_act ? HEIGHT_LOG2'(v_cnt_q) : '0;
        end

        if (frame_wrap) begin
            if (frame_cnt_q == F_LAST) begin
                frame_cnt_d  = '0;
                anim_frame_d = anim_frame_q + 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= '0;
            pix_en_q      <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            to_display_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            anim_frame_q  <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_en_q      <= pix_en_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            to_display_q  <= to_display_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            anim_frame_q  <= anim_frame_d;
        end
    end

    // Stage 0 registers the raw syncs alongside x/y; the remaining
    // SYNC_DELAY stages cover the Renderer's pipeline latency.
    sync_delay_line #(
        .DEPTH(SYNC_DELAY + 1),
        .WIDTH(2)
    ) u_sync_dly (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en_q),
        .din  (raw_sync),
        .dout (sync_dly)
    );

    assign pix_en      = pix_en_q;
    assign x           = x_q;
    assign y           = y_q;
    assign toDisplay   = to_display_q;
    assign hsync       = sync_dly[1];
    assign vsync       = sync_dly[0];
    assign frame_start = frame_start_q;
    assign anim_frame  = anim_frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock:
//   u_dut   default 640x480 timing, PIX_DIV=4, SYNC_DELAY=1
//   u_fast  default timing, PIX_DIV=1, SYNC_DELAY=0
//   u_small 16x10 raster, PIX_DIV=2, SYNC_DELAY=2, ANIM_DIV=3, so whole
//           frames, animation wrap and a mid-frame reset fit a short run.
// Outputs are sampled on the falling clock edge.
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_f = 1'b1;
    logic rst_s = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    logic       pe_a, td_a, hs_a, vs_a, fs_a;
    logic [9:0] x_a;
    logic [8:0] y_a;
    logic [2:0] af_a;
    logic       pe_f, td_f, hs_f, vs_f, fs_f;
    logic [9:0] x_f;
    logic [8:0] y_f;
    logic [2:0] af_f;
    logic       pe_s, td_s, hs_s, vs_s, fs_s;
    logic [9:0] x_s;
    logic [8:0] y_s;
    logic [2:0] af_s;

    vga_timing_gen #(.PIX_DIV(4), .SYNC_DELAY(1)) u_dut (
        .clk(clk), .rst(rst_a), .pix_en(pe_a), .x(x_a), .y(y_a), .toDisplay(td_a),
        .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a), .anim_frame(af_a)
    );

    vga_timing_gen #(.PIX_DIV(1), .SYNC_DELAY(0)) u_fast (
        .clk(clk), .rst(rst_f), .pix_en(pe_f), .x(x_f), .y(y_f), .toDisplay(td_f),
        .hsync(hs_f), .vsync(vs_f), .frame_start(fs_f), .anim_frame(af_f)
    );

    vga_timing_gen #(
        .PIX_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(2), .ANIM_DIV(3)
    ) u_small (
        .clk(clk), .rst(rst_s), .pix_en(pe_s), .x(x_s), .y(y_s), .toDisplay(td_s),
        .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s), .anim_frame(af_s)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_pass = 0;
    logic [2:0] exp_q[$];
    int         n_fs = 0;
    int         last_fs_cyc = -1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Active-low sync level for counter value c.
    function automatic int sync_exp(input int c, input int act, input int fp, input int sw);
        return ((c >= act + fp) && (c < act + fp + sw)) ? 0 : 1;
    endfunction

    // ---------------- driver tasks ----------------
    // Wait for the next pixel strobe of instance `which` (0: u_dut, 2: u_small),
    // then step one more clk so the registered outputs of that tick are visible.
    task automatic next_tick(input int which, output int fs_wait);
        int   n;
        logic pe;
        n = 0;
        fs_wait = 0;
        do begin
            @(negedge clk);
            n++;
            pe = (which == 0) ? pe_a : pe_s;
            if (which == 2 && fs_s) fs_wait++;
        end while (pe !== 1'b1 && n < 16);
        if (pe !== 1'b1) check_eq("pix_en_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag, input logic pe, input logic [9:0] xv,
                                    input logic [8:0] yv, input logic td, input logic hs,
                                    input logic vs, input logic fs, input logic [2:0] af);
        check_eq({tag, "_pix_en"}, pe, 0);
        check_eq({tag, "_x"}, xv, 0);
        check_eq({tag, "_y"}, yv, 0);
        check_eq({tag, "_td"}, td, 0);
        check_eq({tag, "_hsync"}, hs, 1);
        check_eq({tag, "_vsync"}, vs, 1);
        check_eq({tag, "_fs"}, fs, 0);
        check_eq({tag, "_anim"}, af, 0);
    endtask

    // Tick t counts pixel ticks of u_small since its reset release.
    task automatic small_scan(input int t0, input int t1);
        int fs_wait, h, v, tt, hs_e, vs_e;
        for (int t = t0; t <= t1; t++) begin
            next_tick(2, fs_wait);
            h  = t % 16;
            v  = (t / 16) % 10;
            tt = t - 2;
            hs_e = (tt < 0) ? 1 : sync_exp(tt % 16, 8, 2, 3);
            vs_e = (tt < 0) ? 1 : sync_exp((tt / 16) % 10, 6, 1, 2);
            check_eq("s_x", x_s, (h < 8) ? h : 0);
            check_eq("s_y", y_s, (v < 6) ? v : 0);
            check_eq("s_td", td_s, (h < 8 && v < 6) ? 1 : 0);
            check_eq("s_hsync", hs_s, hs_e);
            check_eq("s_vsync", vs_s, vs_e);
            check_eq("s_fs", fs_s, (t % 160 == 159) ? 1 : 0);
            check_eq("s_fs_width", fs_wait, 0);
            check_eq("s_anim", af_s, ((t + 1) / 160 / 3) % 8);
            if (fs_s) begin
                n_fs++;
                if (last_fs_cyc >= 0) check_eq("s_fs_period", cyc - last_fs_cyc, 320);
                last_fs_cyc = cyc;
                if (exp_q.size() > 0) check_eq("s_anim_at_fs", af_s, exp_q.pop_front());
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fs_wait, h, hs_e, hs_low, hs_first;

        // Reset values on all instances.
        repeat (3) @(negedge clk);
        check_reset_vals("a_rst", pe_a, x_a, y_a, td_a, hs_a, vs_a, fs_a, af_a);
        check_reset_vals("f_rst", pe_f, x_f, y_f, td_f, hs_f, vs_f, fs_f, af_f);
        check_reset_vals("s_rst", pe_s, x_s, y_s, td_s, hs_s, vs_s, fs_s, af_s);

        // u_dut: first strobe after four clks, first pixel one clk later.
        rst_a = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            check_eq("a_pix_en_idle", pe_a, 0);
        end
        @(negedge clk);
        check_eq("a_pix_en_first", pe_a, 1);
        check_eq("a_td_before_first", td_a, 0);
        @(negedge clk);
        check_eq("a_pix_en_low", pe_a, 0);
        check_eq("a_first_td", td_a, 1);
        check_eq("a_first_x", x_a, 0);
        check_eq("a_first_y", y_a, 0);
        check_eq("a_first_hsync", hs_a, 1);
        for (int e = 6; e <= 8; e++) begin
            @(negedge clk);
            check_eq("a_pix_en_period", pe_a, (e == 8) ? 1 : 0);
            check_eq("a_x_hold", x_a, 0);
        end
        @(negedge clk);
        check_eq("a_second_x", x_a, 1);
        check_eq("a_second_td", td_a, 1);

        // u_dut: rest of line 0 and the start of line 1.
        hs_low = 0;
        hs_first = -1;
        for (int t = 2; t <= 801; t++) begin
            next_tick(0, fs_wait);
            h = t % 800;
            hs_e = sync_exp((t - 1) % 800, 640, 16, 96);
            check_eq("a_x", x_a, (h < 640) ? h : 0);
            check_eq("a_y", y_a, t / 800);
            check_eq("a_td", td_a, (h < 640) ? 1 : 0);
            check_eq("a_hsync", hs_a, hs_e);
            check_eq("a_vsync", vs_a, 1);
            check_eq("a_fs", fs_a, 0);
            if (hs_a == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = t;
            end
        end
        check_eq("a_hsync_low_ticks", hs_low, 96);
        check_eq("a_hsync_fall_tick", hs_first, 657);

        // u_fast: strobe every clk, syncs aligned with x.
        @(negedge clk);
        rst_f = 1'b0;
        for (int e = 1; e <= 760; e++) begin
            @(negedge clk);
            check_eq("f_pix_en", pe_f, 1);
            if (e == 1) begin
                check_eq("f_td_before_first", td_f, 0);
                check_eq("f_hsync_before_first", hs_f, 1);
            end else begin
                h = e - 2;
                check_eq("f_x", x_f, (h < 640) ? h : 0);
                check_eq("f_y", y_f, 0);
                check_eq("f_td", td_f, (h < 640) ? 1 : 0);
                check_eq("f_hsync", hs_f, sync_exp(h, 640, 16, 96));
                check_eq("f_vsync", vs_f, 1);
                check_eq("f_fs", fs_f, 0);
            end
        end

        // u_small: 25 whole frames, covering the animation wrap.
        for (int k = 1; k <= 25; k++) exp_q.push_back(3'((k / 3) % 8));
        @(negedge clk);
        rst_s = 1'b0;
        small_scan(0, 3999);
        check_eq("s_frames_seen", n_fs, 25);
        check_eq("s_exp_q_empty", exp_q.size(), 0);

        // u_small: reset in the middle of a frame at (5,3).
        small_scan(4000, 4053);
        check_eq("s_mid_x", x_s, 5);
        check_eq("s_mid_y", y_s, 3);
        #1 rst_s = 1'b1;
        #1 check_reset_vals("s_async_rst", pe_s, x_s, y_s, td_s, hs_s, vs_s, fs_s, af_s);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("s_rst_hold", pe_s, x_s, y_s, td_s, hs_s, vs_s, fs_s, af_s);
        rst_s = 1'b0;
        last_fs_cyc = -1;
        small_scan(0, 165);
        check_eq("s_frames_after_rst", n_fs, 26);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
